// File: rtl/l2_request_arbiter_if.sv
`default_nettype none
//==========================================================================
// l2_request_arbiter_if : L2 requester port bundle (request + write data)
// Rev 1.0
//==========================================================================
interface l2_request_arbiter_if #(
  parameter int ADDR_W  = 30,
  parameter int BURST_W = 5,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic               l2_valid;
  logic [ADDR_W-1:0]  l2_addr;
  logic               l2_rnw;
  logic [BURST_W-1:0] l2_len;
  logic [ID_W-1:0]    l2_id;
  logic               l2_ready;
  logic [DATA_W-1:0]  l2_wr_data;
  logic               l2_wr_valid;
  logic               l2_wr_ready;

  modport master (
    output l2_valid, l2_addr, l2_rnw, l2_len, l2_id, l2_wr_data, l2_wr_valid,
    input  l2_ready, l2_wr_ready
  );

  modport slave (
    input  l2_valid, l2_addr, l2_rnw, l2_len, l2_id, l2_wr_data, l2_wr_valid,
    output l2_ready, l2_wr_ready
  );
endinterface
`default_nettype wire

// File: rtl/l2_request_arbiter.sv
`default_nettype none
//==========================================================================
// l2_request_arbiter : round-robin share of one L2 port, grant locked per burst
// Rev 1.0
//==========================================================================
module l2_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 30,
  parameter int BURST_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]         req_rnw_i,
  input  logic [NUM_REQ*BURST_W-1:0] req_len_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]  wr_data_i,
  input  logic [NUM_REQ-1:0]         wr_data_valid_i,
  output logic [NUM_REQ-1:0]         wr_data_ready_o,
  l2_request_arbiter_if.master       l2,
  output logic                       busy_o
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WDATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [BURST_W-1:0] len_arr  [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_len_i[g*BURST_W +: BURST_W];
    assign data_arr[g] = wr_data_i[g*DATA_W +: DATA_W];
  end

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W:0]   scan;
  logic [ID_W-1:0] next_ptr;
  logic            wr_hs;

  assign next_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_q + 1'b1);
  assign wr_hs    = wr_data_valid_i[grant_q] & l2.l2_wr_ready;

  // Scan downward in distance from rr_ptr so the closest valid source wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (req_valid_i[scan[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (l2.l2_ready) begin
          if (req_rnw_i[grant_q]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            state_d    = ST_WDATA;
            beat_cnt_d = len_arr[grant_q];
          end
        end
      end
      ST_WDATA: begin
        if (wr_hs) begin
          if (beat_cnt_q == '0) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while rst is high, even before the state register clears.
  always_comb begin
    req_ready_o     = '0;
    wr_data_ready_o = '0;
    busy_o          = 1'b0;
    l2.l2_valid     = 1'b0;
    l2.l2_addr      = '0;
    l2.l2_rnw       = 1'b0;
    l2.l2_len       = '0;
    l2.l2_id        = '0;
    l2.l2_wr_valid  = 1'b0;
    l2.l2_wr_data   = '0;
    if (!rst) begin
      busy_o = (state_q != ST_IDLE);
      unique case (state_q)
        ST_ISSUE: begin
          l2.l2_valid          = 1'b1;
          l2.l2_addr           = addr_arr[grant_q];
          l2.l2_rnw            = req_rnw_i[grant_q];
          l2.l2_len            = len_arr[grant_q];
          l2.l2_id             = grant_q;
          req_ready_o[grant_q] = l2.l2_ready;
        end
        ST_WDATA: begin
          l2.l2_wr_valid           = wr_data_valid_i[grant_q];
          l2.l2_wr_data            = data_arr[grant_q];
          wr_data_ready_o[grant_q] = l2.l2_wr_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  a_hold_valid_in_issue: assert property (@(posedge clk) disable iff (rst)
    !(state_q == ST_ISSUE && !req_valid_i[grant_q]));

endmodule
`default_nettype wire
